// File: rtl/ps2_keyboard_pkg.sv
// ps2_keyboard_pkg: shared receive-FSM states, register offsets, status bit positions and IRQ vector
package ps2_keyboard_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_e;
  localparam logic [63:0] DATA_OFS = 64'd0;
  localparam logic [63:0] STAT_OFS = 64'd8;
  localparam int STAT_IRQ_EN = 7;
  localparam int STAT_OVF = 6;
  localparam int STAT_PAR_ERR = 5;
  localparam int STAT_NONEMPTY = 4;
  localparam logic [3:0] KBD_IRQ_VEC = 4'd1;
endpackage

// File: rtl/ps2_keyboard_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrapping pointers; push and pop together are both accepted even when full
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic wr_ok, rd_ok;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign count = count_q;
  assign head = mem_q[rd_ptr_q];
  assign wr_ok = push & (~full | pop);
  assign rd_ok = pop & ~empty;
  // next pointer and occupancy values
  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
  end
  // pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // storage array carries no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 receiver with scancode FIFO, DATA/STATUS bus registers and maskable interrupt
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0010,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [63:0] bus_address,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  input  logic [63:0] bus_write_data,
  output logic [63:0] bus_read_data,
  output logic [3:0]  interrupt_vector,
  input  logic        interrupt_ack
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [2:0] clk_sync_q, clk_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;
  ps2_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic ok_q, ok_d, bad_q, bad_d;
  logic rd_en_q, rd_en_d;
  logic irq_en_q, irq_en_d, ovf_q, ovf_d, par_err_q, par_err_d, masked_q, masked_d;
  logic [3:0] vec_q, vec_d;
  logic fall, bit_in, is_data, is_stat, pop, wr_stat;
  logic [7:0] head, status;
  logic [CW-1:0] count;
  logic full, empty;
  logic unused_ok;
  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in = dat_sync_q[1];
  assign is_data = bus_address == BASE_ADDR + DATA_OFS;
  assign is_stat = bus_address == BASE_ADDR + STAT_OFS;
  assign pop = bus_read_enable & ~rd_en_q & is_data & ~empty;
  assign wr_stat = bus_write_enable & is_stat;
  assign interrupt_vector = vec_q;
  assign unused_ok = &{1'b0, bus_write_data[63:3]};
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(reset), .push(ok_q), .push_data(shift_q), .pop(pop),
    .head(head), .count(count), .full(full), .empty(empty)
  );
  // synchronizers plus receive FSM with idle timeout; frame verdict is registered for next-cycle push
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    parity_d = parity_q;
    to_cnt_d = '0;
    ok_d = 1'b0;
    bad_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (fall && !bit_in) begin
        state_d = ST_DATA;
        bit_cnt_d = '0;
      end
    end else if (fall) begin
      case (state_q)
        ST_DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d = bit_cnt_q == 3'd7 ? ST_PARITY : ST_DATA;
        end
        ST_PARITY: begin
          parity_d = bit_in;
          state_d = ST_STOP;
        end
        default: begin
          ok_d = (^{shift_q, parity_q}) & bit_in;
          bad_d = ~ok_d;
          state_d = ST_IDLE;
        end
      endcase
    end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
      state_d = ST_IDLE;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end
  // status flags, interrupt mask and registered vector; a set beats a same-cycle clear
  always_comb begin
    rd_en_d = bus_read_enable;
    irq_en_d = wr_stat ? bus_write_data[0] : irq_en_q;
    ovf_d = (ok_q & full & ~pop) | (ovf_q & ~(wr_stat & bus_write_data[1]));
    par_err_d = bad_q | (par_err_q & ~(wr_stat & bus_write_data[2]));
    masked_d = interrupt_ack | (masked_q & ~pop & ~empty);
    vec_d = (irq_en_q & ~empty & ~masked_q) ? KBD_IRQ_VEC : 4'd0;
  end
  // combinational bus read mux
  always_comb begin
    status = '0;
    status[3:0] = 4'(count);
    status[STAT_NONEMPTY] = ~empty;
    status[STAT_PAR_ERR] = par_err_q;
    status[STAT_OVF] = ovf_q;
    status[STAT_IRQ_EN] = irq_en_q;
    bus_read_data = is_data ? {56'b0, empty ? 8'h00 : head} : is_stat ? {56'b0, status} : 64'b0;
  end
  // all control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      state_q <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q <= '0;
      parity_q <= 1'b0;
      to_cnt_q <= '0;
      ok_q <= 1'b0;
      bad_q <= 1'b0;
      rd_en_q <= 1'b0;
      irq_en_q <= 1'b1;
      ovf_q <= 1'b0;
      par_err_q <= 1'b0;
      masked_q <= 1'b0;
      vec_q <= 4'd0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      parity_q <= parity_d;
      to_cnt_q <= to_cnt_d;
      ok_q <= ok_d;
      bad_q <= bad_d;
      rd_en_q <= rd_en_d;
      irq_en_q <= irq_en_d;
      ovf_q <= ovf_d;
      par_err_q <= par_err_d;
      masked_q <= masked_d;
      vec_q <= vec_d;
    end
  end
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed PS/2 frames against a byte scoreboard and register expectations
module tb_ps2_keyboard;
  localparam logic [63:0] BASE = 64'h8000_0010;
  localparam logic [63:0] STAT = BASE + 64'd8;
  localparam int TO = 200;
  logic clk = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [63:0] bus_address = '0, bus_write_data = '0, bus_read_data;
  logic bus_read_enable = 1'b0, bus_write_enable = 1'b0, interrupt_ack = 1'b0;
  logic [3:0] interrupt_vector;
  logic [7:0] exp_q[$];
  int n_cmp = 0, n_err = 0;
  logic [63:0] rd;
  ps2_keyboard #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .bus_address(bus_address), .bus_read_enable(bus_read_enable),
    .bus_write_enable(bus_write_enable), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data), .interrupt_vector(interrupt_vector),
    .interrupt_ack(interrupt_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
  endtask
  task automatic send(input logic [7:0] d, input logic flip);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(~^d ^ flip);
    ps2_bit(1'b1);
    if (!flip && exp_q.size() < 8) exp_q.push_back(d);
    repeat (4) @(negedge clk);
  endtask
  task automatic stat(output logic [63:0] d);
    bus_address = STAT;
    #1 d = bus_read_data;
  endtask
  task automatic read_pop(input string tag);
    logic [7:0] e;
    e = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
    bus_address = BASE;
    bus_read_enable = 1'b1;
    #1 chk(tag, bus_read_data, {56'b0, e});
    @(negedge clk);
    bus_read_enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic wr_reg(input logic [63:0] a, input logic [63:0] d);
    bus_address = a;
    bus_write_data = d;
    bus_write_enable = 1'b1;
    @(negedge clk);
    bus_write_enable = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_vec", 64'(interrupt_vector), 64'd0);
    stat(rd); chk("rst_status", rd, 64'h80);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    bus_address = BASE; #1 chk("empty_data", bus_read_data, 64'd0);
    bus_address = BASE + 64'd16; #1 chk("other_addr", bus_read_data, 64'd0);
    send(8'h1C, 1'b0);
    stat(rd); chk("s1_status", rd, 64'h91);
    chk("s1_vec", 64'(interrupt_vector), 64'd1);
    read_pop("s1_read");
    stat(rd); chk("s1_status_after", rd, 64'h80);
    chk("s1_vec_after", 64'(interrupt_vector), 64'd0);
    send(8'h1C, 1'b1);
    stat(rd); chk("s2_parerr", rd, 64'hA0);
    wr_reg(BASE + 64'd16, 64'h0);
    stat(rd); chk("s2_other_wr", rd, 64'hA0);
    wr_reg(STAT, 64'h05);
    stat(rd); chk("s2_cleared", rd, 64'h80);
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
    stat(rd); chk("s3_full_ovf", rd, 64'hD8);
    for (int i = 0; i < 8; i++) read_pop("s3_read");
    wr_reg(STAT, 64'h03);
    stat(rd); chk("s3_ovf_clr", rd, 64'h80);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    chk("s4_vec_pre", 64'(interrupt_vector), 64'd1);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("s4_vec_masked", 64'(interrupt_vector), 64'd0);
    read_pop("s4_read1");
    chk("s4_vec_unmask", 64'(interrupt_vector), 64'd1);
    read_pop("s4_read2");
    chk("s4_vec_empty", 64'(interrupt_vector), 64'd0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TO + 5) @(negedge clk);
    send(8'h5A, 1'b0);
    stat(rd); chk("s5_timeout", rd, 64'h91);
    read_pop("s5_read");
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    bus_address = BASE;
    bus_read_enable = 1'b1;
    #1 chk("s6_head", bus_read_data, {56'b0, exp_q.pop_front()});
    repeat (3) @(negedge clk);
    bus_read_enable = 1'b0;
    @(negedge clk);
    stat(rd); chk("s6_one_pop", rd, 64'h91);
    read_pop("s6_read2");
    send(8'h3C, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1 chk("s7_rst_vec", 64'(interrupt_vector), 64'd0);
    stat(rd); chk("s7_rst_status", rd, 64'h80);
    bus_address = BASE; #1 chk("s7_rst_data", bus_read_data, 64'd0);
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h2B, 1'b0);
    stat(rd); chk("s7_post_status", rd, 64'h91);
    read_pop("s7_post_read");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 The block SHALL expose the following parameters:
- BASE_ADDR, default 64'h8000_0010; DATA register address.
- FIFO_DEPTH, default 8; scancode FIFO entries, power of 2.
- TIMEOUT, default 50000; idle clk cycles before an in-progress frame is aborted.
REQ-002 The block SHALL expose the following ports, clock and reset first:
- clk, input, 1; system clock. One clock; reset is asynchronous and active-low.
- reset, input, 1; asynchronous active-low reset.
- ps2_clk, input, 1; PS/2 clock, asynchronous to clk.
- ps2_data, input, 1; PS/2 data, asynchronous to clk.
- bus_address, input, 64; core bus address.
- bus_read_enable, input, 1; core read strobe.
- bus_write_enable, input, 1; core write strobe.
- bus_write_data, input, 64; core write data.
- bus_read_data, output, 64; read data.
- interrupt_vector, output, 4; interrupt request to core, value 1 = keyboard.
- interrupt_ack, input, 1; one-cycle acknowledge pulse from core.

Function
REQ-003 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a PS/2 bit is sampled on the clk cycle detecting a synchronized ps2_clk 1->0 transition.
REQ-004 The receive FSM SHALL have the states IDLE, DATA, PARITY and STOP:
- IDLE->DATA on a sampled 0 (start bit); a sampled 1 stays in IDLE.
- DATA: shift 8 bits LSB first, then go to PARITY.
- PARITY: capture the bit, then go to STOP.
- STOP: capture the bit, then go to IDLE.
REQ-005 A frame SHALL be valid only if the parity is odd over data+parity and the stop bit is 1; a valid byte is pushed to the FIFO in the cycle after the stop sample.
REQ-006 An invalid frame SHALL be discarded and SHALL set sticky status bit par_err.
REQ-007 In any non-IDLE state, TIMEOUT clk cycles without a ps2_clk falling edge SHALL return the FSM to IDLE and discard the partial byte; no error bit is set.
REQ-008 The FIFO SHALL be synchronous, FIFO_DEPTH entries of 8 bits, with wrapping read/write pointers and a count of width log2(FIFO_DEPTH)+1.
REQ-009 A push when the FIFO is full and no pop occurs in the same cycle SHALL drop the byte and set sticky status bit ovf.
REQ-010 A simultaneous push and pop SHALL both be accepted, including when full; count is unchanged.
REQ-011 bus_read_data SHALL be combinational, zero latency:
- address == BASE_ADDR: {56'b0, FIFO head}, or 64'b0 if the FIFO is empty.
- address == BASE_ADDR+8: {56'b0, irq_en, ovf, par_err, nonempty, count[3:0]} in bits [7:0], ordered MSB..LSB.
- any other address: 64'b0.
REQ-012 A pop SHALL occur only on the clk edge where bus_read_enable is high, was low the previous cycle, and address == BASE_ADDR with the FIFO non-empty; a held read strobe pops once.
REQ-013 A write with address == BASE_ADDR+8 SHALL act as follows:
- bit0 loads irq_en.
- bit1 = 1 clears ovf.
- bit2 = 1 clears par_err.
- A clear and a set in the same cycle: the set wins.
REQ-014 Writes and reads to any other address SHALL be ignored.
REQ-015 interrupt_vector SHALL be 4'd1 when irq_en, FIFO non-empty and irq_masked = 0; otherwise it SHALL be 4'd0. The output is registered, one cycle after the condition.
REQ-016 interrupt_ack = 1 SHALL set irq_masked.
REQ-017 irq_masked SHALL be cleared by the next pop (REQ-012) or when the FIFO becomes empty.

Reset
REQ-018 While reset = 0, the block SHALL hold the following values:
- FSM = IDLE.
- FIFO empty, pointers 0.
- ovf = par_err = 0.
- irq_en = 1, irq_masked = 0.
- interrupt_vector = 0.
- synchronizers = 1.
- timeout counter = 0.
REQ-019 Reset asserted mid-frame SHALL discard the frame; the first frame after release SHALL be received normally.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, the DATA and STATUS address offsets (0, 8), the STATUS bit positions and the keyboard interrupt vector value 1.
REQ-021 The FIFO SHALL be a separate sub-module, sync_fifo, parameterized on width and depth, and reusable by the UART block.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Send frame 0x1C with correct parity -> count = 1, interrupt_vector = 1 within 3 cycles; read BASE_ADDR -> 0x1C, then count = 0, vector = 0.
- Send 0x1C with parity flipped -> FIFO stays empty, STATUS bit5 = 1; write STATUS 0x05 -> bit5 = 0.
- Send 9 valid frames 0x01..0x09 with no reads -> count = 8, ovf = 1; eight reads return 0x01..0x08 in order.
- Assert interrupt_ack with 2 bytes queued -> vector = 0; after one pop -> vector = 1; after the second pop -> vector = 0.
- Stop ps2_clk after 4 data bits for TIMEOUT+1 cycles, then send 0x5A -> only 0x5A queued, par_err = 0.
- Hold bus_read_enable for 3 cycles at BASE_ADDR with 2 bytes queued -> exactly one pop; assert reset mid-frame -> all outputs at reset values.
